// File: rtl/mem_burst_master.sv
// Single-outstanding burst master: streams read words to a consumer, or fills a
// range of memory with one word, with a per-access completion timeout.
module mem_burst_master #(
    parameter int ADDR_BITS      = 16,
    parameter int WORD_BITS      = 16,
    parameter int LEN_BITS       = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 in_clk,
    input  logic                 in_rst,
    input  logic                 in_start,
    input  logic                 in_fill,
    input  logic [ADDR_BITS-1:0] in_addr,
    input  logic [LEN_BITS-1:0]  in_count,
    input  logic [WORD_BITS-1:0] in_fill_data,
    output logic                 out_mem_ready,
    output logic                 out_mem_write,
    output logic [ADDR_BITS-1:0] out_mem_addr,
    output logic [WORD_BITS-1:0] out_mem_data,
    input  logic                 in_mem_ready,
    input  logic [WORD_BITS-1:0] in_mem_data,
    output logic [WORD_BITS-1:0] out_word,
    output logic                 out_word_valid,
    input  logic                 in_word_ready,
    output logic                 out_busy,
    output logic                 out_finished,
    output logic                 out_error
);

    // state  | meaning
    // IDLE   | waiting for in_start
    // ISSUE  | request outstanding (or one gap cycle when out_mem_ready=0)
    // STREAM | read word held on out_word until the consumer accepts it
    // DONE   | one-cycle out_finished pulse
    // ERROR  | memory did not answer in time; one cycle before IDLE

    localparam int TO_BITS = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_BITS-1:0] TO_LOAD = TO_BITS'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, STREAM, DONE, ERROR} state_t;

    state_t               state;
    logic [LEN_BITS-1:0]  remaining;
    logic [TO_BITS-1:0]   timer;

    // out_mem_addr doubles as the current address and out_mem_write as the mode flag.
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            state          <= IDLE;
            remaining      <= '0;
            timer          <= '0;
            out_mem_ready  <= 1'b0;
            out_mem_write  <= 1'b0;
            out_mem_addr   <= '0;
            out_mem_data   <= '0;
            out_word       <= '0;
            out_word_valid <= 1'b0;
            out_busy       <= 1'b0;
            out_finished   <= 1'b0;
            out_error      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_start) begin
                        out_error     <= 1'b0;
                        out_busy      <= 1'b1;
                        remaining     <= in_count;
                        out_mem_addr  <= in_addr;
                        out_mem_write <= in_fill;
                        out_mem_data  <= in_fill ? in_fill_data : '0;
                        timer         <= TO_LOAD;
                        if (in_count == '0) begin
                            state        <= DONE;
                            out_finished <= 1'b1;
                        end else begin
                            state         <= ISSUE;
                            out_mem_ready <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (!out_mem_ready) begin
                        // gap cycle between fill writes
                        out_mem_ready <= 1'b1;
                        timer         <= TO_LOAD;
                    end else if (in_mem_ready) begin
                        out_mem_ready <= 1'b0;
                        if (out_mem_write) begin
                            remaining    <= remaining - 1'b1;
                            out_mem_addr <= out_mem_addr + 1'b1;
                            if (remaining == LEN_BITS'(1)) begin
                                state        <= DONE;
                                out_finished <= 1'b1;
                            end
                        end else begin
                            out_word       <= in_mem_data;
                            out_word_valid <= 1'b1;
                            state          <= STREAM;
                        end
                    end else if (timer == '0) begin
                        out_mem_ready <= 1'b0;
                        out_error     <= 1'b1;
                        state         <= ERROR;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                STREAM: begin
                    if (in_word_ready) begin
                        out_word_valid <= 1'b0;
                        remaining      <= remaining - 1'b1;
                        out_mem_addr   <= out_mem_addr + 1'b1;
                        if (remaining == LEN_BITS'(1)) begin
                            state        <= DONE;
                            out_finished <= 1'b1;
                        end else begin
                            state         <= ISSUE;
                            out_mem_ready <= 1'b1;
                            timer         <= TO_LOAD;
                        end
                    end
                end
                DONE: begin
                    out_finished <= 1'b0;
                    out_busy     <= 1'b0;
                    state        <= IDLE;
                end
                ERROR: begin
                    out_busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_burst_master.sv
// Directed bench for mem_burst_master: read/fill bursts, backpressure, wrap,
// timeout and mid-burst reset, with hand-computed expectations.
module tb_mem_burst_master;

    logic        in_clk;
    logic        in_rst;
    logic        in_start;
    logic        in_fill;
    logic [15:0] in_addr;
    logic [15:0] in_count;
    logic [15:0] in_fill_data;
    logic        out_mem_ready;
    logic        out_mem_write;
    logic [15:0] out_mem_addr;
    logic [15:0] out_mem_data;
    logic        in_mem_ready;
    logic [15:0] in_mem_data;
    logic [15:0] out_word;
    logic        out_word_valid;
    logic        in_word_ready;
    logic        out_busy;
    logic        out_finished;
    logic        out_error;

    int checks   = 0;
    int failures = 0;

    mem_burst_master dut (
        .in_clk        (in_clk),
        .in_rst        (in_rst),
        .in_start      (in_start),
        .in_fill       (in_fill),
        .in_addr       (in_addr),
        .in_count      (in_count),
        .in_fill_data  (in_fill_data),
        .out_mem_ready (out_mem_ready),
        .out_mem_write (out_mem_write),
        .out_mem_addr  (out_mem_addr),
        .out_mem_data  (out_mem_data),
        .in_mem_ready  (in_mem_ready),
        .in_mem_data   (in_mem_data),
        .out_word      (out_word),
        .out_word_valid(out_word_valid),
        .in_word_ready (in_word_ready),
        .out_busy      (out_busy),
        .out_finished  (out_finished),
        .out_error     (out_error)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (out_mem_ready !== 1'b1 && n < 20) begin
            @(negedge in_clk);
            n++;
        end
        chk(tag, 32'(out_mem_ready), 32'd1);
    endtask

    task automatic start(input logic fill, input logic [15:0] a, input logic [15:0] cnt,
                         input logic [15:0] fd);
        in_start     = 1'b1;
        in_fill      = fill;
        in_addr      = a;
        in_count     = cnt;
        in_fill_data = fd;
        @(negedge in_clk);
        in_start = 1'b0;
        in_addr  = 16'h0;
        in_count = 16'h0;
    endtask

    // responder acks two cycles after the request is seen; consumer stalls 'hold' cycles
    task automatic rd_access(input logic [15:0] a, input logic [15:0] w, input int hold,
                             input bit last);
        wait_valid("rd_valid");
        chk("rd_addr", 32'(out_mem_addr), 32'(a));
        chk("rd_write", 32'(out_mem_write), 32'd0);
        repeat (2) begin
            @(negedge in_clk);
            chk("rd_valid_hold", 32'(out_mem_ready), 32'd1);
        end
        in_mem_ready = 1'b1;
        in_mem_data  = w;
        @(negedge in_clk);
        in_mem_ready = 1'b0;
        in_mem_data  = 16'h0;
        chk("rd_valid_drop", 32'(out_mem_ready), 32'd0);
        chk("word_valid", 32'(out_word_valid), 32'd1);
        chk("word", 32'(out_word), 32'(w));
        for (int i = 0; i < hold; i++) begin
            @(negedge in_clk);
            chk("bp_word", 32'(out_word), 32'(w));
            chk("bp_valid", 32'(out_word_valid), 32'd1);
            chk("bp_mem_ready", 32'(out_mem_ready), 32'd0);
        end
        in_word_ready = 1'b1;
        @(negedge in_clk);
        in_word_ready = 1'b0;
        chk("word_valid_clr", 32'(out_word_valid), 32'd0);
        if (last) begin
            chk("finished", 32'(out_finished), 32'd1);
            chk("mem_ready_done", 32'(out_mem_ready), 32'd0);
            @(negedge in_clk);
            chk("finished_once", 32'(out_finished), 32'd0);
            chk("busy_after", 32'(out_busy), 32'd0);
        end else begin
            chk("next_req", 32'(out_mem_ready), 32'd1);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        in_rst        = 1'b1;
        in_start      = 1'b0;
        in_fill       = 1'b0;
        in_addr       = 16'h0;
        in_count      = 16'h0;
        in_fill_data  = 16'h0;
        in_mem_ready  = 1'b0;
        in_mem_data   = 16'h0;
        in_word_ready = 1'b0;
        #2 in_rst = 1'b0;
        #1;
        chk("rst_mem_ready", 32'(out_mem_ready), 32'd0);
        chk("rst_busy", 32'(out_busy), 32'd0);
        chk("rst_word_valid", 32'(out_word_valid), 32'd0);
        chk("rst_addr", 32'(out_mem_addr), 32'd0);
        chk("rst_error", 32'(out_error), 32'd0);
        repeat (3) @(negedge in_clk);
        in_rst = 1'b1;
        @(negedge in_clk);

        // read burst 0x0010 x3 with backpressure on the first word
        start(1'b0, 16'h0010, 16'd3, 16'h0);
        chk("rd_busy", 32'(out_busy), 32'd1);
        rd_access(16'h0010, 16'h00B0, 10, 1'b0);
        rd_access(16'h0011, 16'h00B1, 0, 1'b0);
        rd_access(16'h0012, 16'h00B2, 0, 1'b1);

        // fill burst 0x03FE x2; a stray start alongside the first ack must be ignored
        start(1'b1, 16'h03FE, 16'd2, 16'h55AA);
        chk("fill_valid0", 32'(out_mem_ready), 32'd1);
        chk("fill_addr0", 32'(out_mem_addr), 32'h03FE);
        chk("fill_write0", 32'(out_mem_write), 32'd1);
        chk("fill_data0", 32'(out_mem_data), 32'h55AA);
        in_mem_ready = 1'b1;
        in_start     = 1'b1;
        in_addr      = 16'h1234;
        in_count     = 16'd0;
        @(negedge in_clk);
        in_mem_ready = 1'b0;
        in_start     = 1'b0;
        chk("fill_gap", 32'(out_mem_ready), 32'd0);
        chk("fill_gap_busy", 32'(out_busy), 32'd1);
        @(negedge in_clk);
        chk("fill_valid1", 32'(out_mem_ready), 32'd1);
        chk("fill_addr1", 32'(out_mem_addr), 32'h03FF);
        chk("fill_write1", 32'(out_mem_write), 32'd1);
        chk("fill_data1", 32'(out_mem_data), 32'h55AA);
        in_mem_ready = 1'b1;
        @(negedge in_clk);
        in_mem_ready = 1'b0;
        chk("fill_finished", 32'(out_finished), 32'd1);
        chk("fill_valid_low", 32'(out_mem_ready), 32'd0);
        @(negedge in_clk);
        chk("fill_finished_once", 32'(out_finished), 32'd0);
        chk("fill_idle", 32'(out_busy), 32'd0);

        // address wrap 0xFFFF -> 0x0000
        start(1'b0, 16'hFFFF, 16'd2, 16'h0);
        rd_access(16'hFFFF, 16'h009F, 0, 1'b0);
        rd_access(16'h0000, 16'h00A0, 0, 1'b1);
        chk("wrap_error", 32'(out_error), 32'd0);

        // timeout: no responder
        start(1'b0, 16'h0020, 16'd1, 16'h0);
        n = 0;
        while (out_mem_ready === 1'b1 && n < 400) begin
            @(negedge in_clk);
            n++;
        end
        chk("to_cycles", 32'(n), 32'd255);
        chk("to_error", 32'(out_error), 32'd1);
        chk("to_busy_err", 32'(out_busy), 32'd1);
        @(negedge in_clk);
        chk("to_busy_idle", 32'(out_busy), 32'd0);
        chk("to_error_held", 32'(out_error), 32'd1);
        @(negedge in_clk);
        chk("to_error_held2", 32'(out_error), 32'd1);
        start(1'b0, 16'h0, 16'd0, 16'h0);
        chk("err_clr_start", 32'(out_error), 32'd0);
        chk("zero_finished", 32'(out_finished), 32'd1);
        @(negedge in_clk);

        // reset during ISSUE of a fill burst
        start(1'b1, 16'h0100, 16'd4, 16'h1111);
        chk("mr_valid", 32'(out_mem_ready), 32'd1);
        #1 in_rst = 1'b0;
        #1;
        chk("mr_mem_ready", 32'(out_mem_ready), 32'd0);
        chk("mr_write", 32'(out_mem_write), 32'd0);
        chk("mr_addr", 32'(out_mem_addr), 32'd0);
        chk("mr_data", 32'(out_mem_data), 32'd0);
        chk("mr_word", 32'(out_word), 32'd0);
        chk("mr_word_valid", 32'(out_word_valid), 32'd0);
        chk("mr_busy", 32'(out_busy), 32'd0);
        chk("mr_finished", 32'(out_finished), 32'd0);
        chk("mr_error", 32'(out_error), 32'd0);
        @(negedge in_clk);
        in_rst = 1'b1;
        repeat (3) begin
            @(negedge in_clk);
            chk("mr_no_resume", 32'(out_mem_ready), 32'd0);
            chk("mr_idle", 32'(out_busy), 32'd0);
        end
        start(1'b0, 16'h0, 16'd0, 16'h0);
        chk("mr_zero_finished", 32'(out_finished), 32'd1);
        chk("mr_zero_no_req", 32'(out_mem_ready), 32'd0);
        @(negedge in_clk);
        chk("mr_zero_once", 32'(out_finished), 32'd0);
        chk("mr_zero_idle", 32'(out_busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
